pulse_meter: RTL and testbench

//   Receive-side companion to the button-triggered pulse generator. Samples an

---
 rtl/pulse_meter.sv | 124 ++++++++++++
 tb/tb_pulse_meter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meter.sv
// Pulse-width meter: synchronizes an async pulse line and reports high time
// in clk cycles, with glitch rejection and overflow detection.
module pulse_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 33,
    parameter int MIN_CYCLES  = 2,
    parameter int MAX_CYCLES  = 2500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] width,
    output logic             width_valid,
    output logic             glitch,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        MEASURE,
        TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_CYCLES);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t                 state;
    state_t                 state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] primed;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_n;
    logic [CNT_W-1:0]       width_n;
    logic                   width_valid_n;
    logic                   glitch_n;
    logic                   overflow_n;
    logic                   s;
    logic                   chain_full;

    assign s          = sync[SYNC_STAGES-1];
    assign chain_full = &primed;
    assign busy       = (state == MEASURE) || (state == TIMEOUT);

    // The chain resets to 0, so its output only reflects real samples of
    // pulse_in once it has been refilled; WAIT_LOW holds until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            primed <= '0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], pulse_in};
            primed <= {primed[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_LOW;
            cnt         <= '0;
            width       <= '0;
            width_valid <= 1'b0;
            glitch      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            width       <= width_n;
            width_valid <= width_valid_n;
            glitch      <= glitch_n;
            overflow    <= overflow_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        width_n       = width;
        width_valid_n = 1'b0;
        glitch_n      = 1'b0;
        overflow_n    = 1'b0;
        unique case (state)
            WAIT_LOW: begin
                if (chain_full && !s) begin
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (s) begin
                    state_n = MEASURE;
                    cnt_n   = ONE;
                end
            end
            MEASURE: begin
                if (s) begin
                    if (cnt == MAX_C) begin
                        overflow_n = 1'b1;
                        state_n    = TIMEOUT;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end else if (cnt < MIN_C) begin
                    glitch_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    width_n       = cnt;
                    width_valid_n = 1'b1;
                    state_n       = IDLE;
                end
            end
            TIMEOUT: begin
                if (!s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = WAIT_LOW;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: reset, width reporting, glitch,
// overflow, back-to-back pulses and mid-pulse reset.
module tb_pulse_meter;

    localparam int CW = 33;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse_in;
    logic [CW-1:0] width;
    logic          width_valid;
    logic          glitch;
    logic          overflow;
    logic          busy;

    always #5 clk = ~clk;

    pulse_meter #(
        .SYNC_STAGES(2),
        .CNT_W      (CW),
        .MIN_CYCLES (4),
        .MAX_CYCLES (1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pulse_in   (pulse_in),
        .width      (width),
        .width_valid(width_valid),
        .glitch     (glitch),
        .overflow   (overflow),
        .busy       (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_wv = 0, n_gl = 0, n_ov = 0, n_multi = 0;
    int wv_cyc = -1, gl_cyc = -1, ov_cyc = -1;
    int busy_hi = 0, busy_last = -1;
    int widths[$];

    always @(negedge clk) begin
        if (width_valid) begin
            n_wv   <= n_wv + 1;
            wv_cyc <= cyc;
            widths.push_back(int'(width));
        end
        if (glitch) begin
            n_gl   <= n_gl + 1;
            gl_cyc <= cyc;
        end
        if (overflow) begin
            n_ov   <= n_ov + 1;
            ov_cyc <= cyc;
        end
        if (int'(width_valid) + int'(glitch) + int'(overflow) > 1)
            n_multi <= n_multi + 1;
        if (busy) begin
            busy_hi   <= busy_hi + 1;
            busy_last <= cyc;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int rise_cyc, fall_cyc;

    task automatic pulse(input int n);
        @(negedge clk);
        pulse_in = 1'b1;
        rise_cyc = cyc;
        repeat (n) @(negedge clk);
        pulse_in = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int b_wv, b_gl, b_ov, b_busy;

    task automatic snap();
        b_wv   = n_wv;
        b_gl   = n_gl;
        b_ov   = n_ov;
        b_busy = busy_hi;
    endtask

    function automatic int flags();
        return int'({width_valid, glitch, overflow, busy});
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        pulse_in = 1'b1;
        idle(3);
        check("rst_width", int'(width), 0);
        check("rst_flags", flags(), 0);

        // 1: partial pulse after reset is ignored
        rst = 1'b0;
        idle(20);
        pulse_in = 1'b0;
        idle(8);
        check("t1_no_strobe", n_wv + n_gl + n_ov, 0);
        check("t1_no_busy", busy_hi, 0);
        pulse(10);
        idle(8);
        check("t1_wv_count", n_wv, 1);
        check("t1_width", int'(width), 10);

        // 2: latency and busy duration
        snap();
        pulse(10);
        idle(8);
        check("t2_wv_count", n_wv - b_wv, 1);
        check("t2_wv_cycle", wv_cyc, fall_cyc + 3);
        check("t2_width", int'(width), 10);
        check("t2_busy_len", busy_hi - b_busy, 10);
        check("t2_busy_end", busy_last, fall_cyc + 2);

        // 3: glitch, MIN boundary, MAX boundary
        snap();
        pulse(3);
        idle(8);
        check("t3_glitch", n_gl - b_gl, 1);
        check("t3_gl_cycle", gl_cyc, fall_cyc + 3);
        check("t3_no_wv", n_wv - b_wv, 0);
        check("t3_width_kept", int'(width), 10);
        pulse(4);
        idle(8);
        check("t3_min_wv", n_wv - b_wv, 1);
        check("t3_min_width", int'(width), 4);
        pulse(1000);
        idle(8);
        check("t3_max_wv", n_wv - b_wv, 2);
        check("t3_max_width", int'(width), 1000);
        check("t3_max_no_ov", n_ov - b_ov, 0);

        // 4: overflow
        snap();
        pulse(1500);
        idle(8);
        check("t4_ov_count", n_ov - b_ov, 1);
        check("t4_ov_cycle", ov_cyc, rise_cyc + 1003);
        check("t4_no_wv", n_wv - b_wv, 0);
        check("t4_no_glitch", n_gl - b_gl, 0);
        check("t4_width_kept", int'(width), 1000);
        check("t4_busy_end", busy_last, fall_cyc + 2);

        // 5: back-to-back with one low sample
        snap();
        widths.delete();
        pulse(8);
        pulse(8);
        idle(8);
        check("t5_wv_count", n_wv - b_wv, 2);
        check("t5_n_widths", widths.size(), 2);
        if (widths.size() == 2) begin
            check("t5_width0", widths[0], 8);
            check("t5_width1", widths[1], 8);
        end

        // 6: reset mid-pulse
        @(negedge clk);
        pulse_in = 1'b1;
        idle(5);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_width", int'(width), 0);
        check("t6_rst_flags", flags(), 0);
        rst = 1'b0;
        snap();
        idle(45);
        pulse_in = 1'b0;
        idle(8);
        check("t6_no_strobe", (n_wv - b_wv) + (n_gl - b_gl) + (n_ov - b_ov), 0);
        pulse(12);
        idle(8);
        check("t6_wv_count", n_wv - b_wv, 1);
        check("t6_width", int'(width), 12);

        check("strobe_exclusive", n_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
